// File: rtl/obi_wb_bridge.sv
// OBI (req/gnt/rvalid) to single-outstanding Wishbone classic master bridge.
// Optional ack timeout with error response: define OBI_WB_TIMEOUT_EN.
module obi_wb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_core,
  input  logic                  rst_core,
  input  logic                  obi_req_i,
  output logic                  obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0] obi_addr_i,
  input  logic                  obi_we_i,
  input  logic [3:0]            obi_be_i,
  input  logic [DATA_WIDTH-1:0] obi_wdata_i,
  output logic                  obi_rvalid_o,
  output logic [DATA_WIDTH-1:0] obi_rdata_o,
  output logic                  obi_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_wstrb_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i
);

  // Byte enables are fixed at four lanes, so only a 32-bit data path is legal.
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("obi_wb_bridge: DATA_WIDTH must be 32 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  cyc_d, we_d, rvalid_d;
  logic [3:0]            wstrb_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rdata_d;

`ifdef OBI_WB_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 err_q, err_d;
  assign obi_err_o = err_q;
`else
  assign obi_err_o = 1'b0;
`endif

  // A new request is accepted only when no Wishbone cycle is in flight.
  assign obi_gnt_o = obi_req_i && (state_q == IDLE || state_q == RESP);

  always_comb begin
    state_d  = state_q;
    cyc_d    = wb_cyc_o;
    we_d     = wb_we_o;
    wstrb_d  = wb_wstrb_o;
    addr_d   = wb_addr_o;
    wdata_d  = wb_data_o;
    rvalid_d = 1'b0;
    rdata_d  = obi_rdata_o;
`ifdef OBI_WB_TIMEOUT_EN
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + CNT_WIDTH'(1);
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (obi_gnt_o) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = obi_we_i;
          wstrb_d = obi_we_i ? obi_be_i : 4'hF;
          addr_d  = obi_addr_i;
          wdata_d = obi_wdata_i;
`ifdef OBI_WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          state_d  = RESP;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = wb_we_o ? '0 : wb_data_i;
        end
`ifdef OBI_WB_TIMEOUT_EN
        // Ack has priority; abandon the cycle only on a clean timeout.
        else if (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
          state_d  = RESP;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q      <= IDLE;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_wstrb_o   <= '0;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
      obi_rvalid_o <= 1'b0;
      obi_rdata_o  <= '0;
`ifdef OBI_WB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wb_cyc_o     <= cyc_d;
      wb_stb_o     <= cyc_d;
      wb_we_o      <= we_d;
      wb_wstrb_o   <= wstrb_d;
      wb_addr_o    <= addr_d;
      wb_data_o    <= wdata_d;
      obi_rvalid_o <= rvalid_d;
      obi_rdata_o  <= rdata_d;
`ifdef OBI_WB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Self-checking bench for obi_wb_bridge: vector table, corner sequences, random traffic vs. a transaction model.
module tb_obi_wb_bridge;

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic        obi_req_i = 1'b0;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i = '0;
  logic        obi_we_i = 1'b0;
  logic [3:0]  obi_be_i = '0;
  logic [31:0] obi_wdata_i = '0;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_wstrb_o;
  logic [31:0] wb_addr_o, wb_data_o;
  logic [31:0] wb_data_i = '0;
  logic        wb_ack_i = 1'b0;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_wstrb_o(wb_wstrb_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdin;
    logic        e_gnt;
    logic        e_cyc;
    logic        e_we;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr;
    logic [31:0] e_wdo;
    logic        e_rvalid;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic we,
                              input logic [3:0] be, input logic [31:0] wdata, input logic ack,
                              input logic [31:0] rdin, input logic e_gnt, input logic e_cyc,
                              input logic e_we, input logic [3:0] e_wstrb, input logic [31:0] e_addr,
                              input logic [31:0] e_wdo, input logic e_rvalid, input logic [31:0] e_rdata);
    vec_t v;
    v.req = req; v.addr = addr; v.we = we; v.be = be; v.wdata = wdata; v.ack = ack; v.rdin = rdin;
    v.e_gnt = e_gnt; v.e_cyc = e_cyc; v.e_we = e_we; v.e_wstrb = e_wstrb; v.e_addr = e_addr;
    v.e_wdo = e_wdo; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk_core);
    rst_core = 1'b1; obi_req_i = 1'b0; wb_ack_i = 1'b0;
    @(negedge clk_core);
    rst_core = 1'b0;
  endtask

  // Issue one read; ack on BUS cycle index ack_at (0 = first); checks response and cyc length.
  task automatic read_txn(input logic [31:0] a, input int unsigned ack_at, input logic [31:0] d,
                          input logic exp_err, input int unsigned exp_len, input string tag);
    int unsigned ncyc;
    bit got;
    ncyc = 0; got = 1'b0;
    @(negedge clk_core);
    obi_req_i = 1'b1; obi_addr_i = a; obi_we_i = 1'b0; obi_be_i = 4'h0;
    #1 chk({tag, "_gnt"}, 32'(obi_gnt_o), 32'd1);
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk_core);
      obi_req_i = 1'b0;
      wb_ack_i  = (n == int'(ack_at));
      wb_data_i = d;
      #1;
      if (obi_rvalid_o) begin
        got = 1'b1;
        chk({tag, "_rdata"}, obi_rdata_o, exp_err ? 32'h0 : d);
        chk({tag, "_err"}, 32'(obi_err_o), 32'(exp_err));
      end else if (wb_cyc_o) begin
        ncyc++;
        chk({tag, "_wstrb"}, 32'(wb_wstrb_o), 32'hF);
        chk({tag, "_addr"}, wb_addr_o, a);
      end
    end
    wb_ack_i = 1'b0;
    chk({tag, "_rvalid_seen"}, 32'(got), 32'd1);
    chk({tag, "_cyc_len"}, ncyc, exp_len);
  endtask

  initial begin
    // cycle-by-cycle vectors: single read, single write, back-to-back, spurious ack, req held in BUS
    vecs[0]  = mk(1, 32'h1000, 0, 4'h0, 32'h0, 0, 32'h0,        1, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 32'h0,    0, 4'h0, 32'h0, 0, 32'h0,        0, 1, 0, 4'hF, 32'h1000, 32'h0,        0, 32'h0);
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = mk(0, 32'h0,    0, 4'h0, 32'h0, 1, 32'hDEADBEEF, 0, 1, 0, 4'hF, 32'h1000, 32'h0,        0, 32'h0);
    vecs[5]  = mk(0, 32'h0,    0, 4'h0, 32'h0, 0, 32'h0,        0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'hDEADBEEF);
    vecs[6]  = mk(0, 32'h0,    0, 4'h0, 32'h0, 0, 32'h0,        0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'hDEADBEEF);
    vecs[7]  = mk(1, 32'h2004, 1, 4'h3, 32'h0000CAFE, 0, 32'h0, 1, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'hDEADBEEF);
    vecs[8]  = mk(0, 32'h0,    0, 4'h0, 32'h0, 1, 32'h0,        0, 1, 1, 4'h3, 32'h2004, 32'h0000CAFE, 0, 32'hDEADBEEF);
    vecs[9]  = mk(0, 32'h0,    0, 4'h0, 32'h0, 0, 32'h0,        0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h0);
    vecs[10] = mk(1, 32'h0,    0, 4'h0, 32'h0, 0, 32'h0,        1, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0);
    vecs[11] = mk(1, 32'h4,    0, 4'h0, 32'h0, 1, 32'h11111111, 0, 1, 0, 4'hF, 32'h0,    32'h0,        0, 32'h0);
    vecs[12] = mk(1, 32'h4,    0, 4'h0, 32'h0, 0, 32'h0,        1, 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h11111111);
    vecs[13] = mk(0, 32'h0,    0, 4'h0, 32'h0, 1, 32'h22222222, 0, 1, 0, 4'hF, 32'h4,    32'h0,        0, 32'h11111111);
    vecs[14] = mk(0, 32'h0,    0, 4'h0, 32'h0, 0, 32'h0,        0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h22222222);
    vecs[15] = mk(0, 32'h0,    0, 4'h0, 32'h0, 1, 32'h33333333, 0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h22222222);
    vecs[16] = mk(0, 32'h0,    0, 4'h0, 32'h0, 0, 32'h0,        0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h22222222);
    vecs[17] = mk(1, 32'h8,    1, 4'hC, 32'hAABBCCDD, 0, 32'h0, 1, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h22222222);
    vecs[18] = mk(1, 32'hC,    0, 4'h0, 32'h0, 0, 32'h0,        0, 1, 1, 4'hC, 32'h8,    32'hAABBCCDD, 0, 32'h22222222);
    vecs[19] = vecs[18];
    vecs[20] = mk(1, 32'hC,    0, 4'h0, 32'h0, 1, 32'h44444444, 0, 1, 1, 4'hC, 32'h8,    32'hAABBCCDD, 0, 32'h22222222);
    vecs[21] = mk(1, 32'hC,    0, 4'h0, 32'h0, 0, 32'h0,        1, 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h0);
    vecs[22] = mk(0, 32'h0,    0, 4'h0, 32'h0, 1, 32'h55555555, 0, 1, 0, 4'hF, 32'hC,    32'h0,        0, 32'h0);
    vecs[23] = mk(0, 32'h0,    0, 4'h0, 32'h0, 0, 32'h0,        0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h55555555);
    vecs[24] = vecs[16];
    vecs[24].e_rdata = 32'h55555555;

    // reset state
    repeat (2) @(negedge clk_core);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_wstrb", 32'(wb_wstrb_o), 32'd0);
    chk("rst_addr", wb_addr_o, 32'd0);
    chk("rst_wdata", wb_data_o, 32'd0);
    chk("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("rst_rdata", obi_rdata_o, 32'd0);
    chk("rst_err", 32'(obi_err_o), 32'd0);
    @(negedge clk_core);
    rst_core = 1'b0;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk_core);
      obi_req_i = vecs[i].req; obi_addr_i = vecs[i].addr; obi_we_i = vecs[i].we;
      obi_be_i = vecs[i].be; obi_wdata_i = vecs[i].wdata;
      wb_ack_i = vecs[i].ack; wb_data_i = vecs[i].rdin;
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(obi_gnt_o), 32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_cyc", i), 32'(wb_cyc_o), 32'(vecs[i].e_cyc));
      chk($sformatf("vec%0d_stb", i), 32'(wb_stb_o), 32'(vecs[i].e_cyc));
      if (vecs[i].e_cyc) begin
        chk($sformatf("vec%0d_we", i), 32'(wb_we_o), 32'(vecs[i].e_we));
        chk($sformatf("vec%0d_wstrb", i), 32'(wb_wstrb_o), 32'(vecs[i].e_wstrb));
        chk($sformatf("vec%0d_addr", i), wb_addr_o, vecs[i].e_addr);
        chk($sformatf("vec%0d_wdata", i), wb_data_o, vecs[i].e_wdo);
      end
      chk($sformatf("vec%0d_rvalid", i), 32'(obi_rvalid_o), 32'(vecs[i].e_rvalid));
      chk($sformatf("vec%0d_rdata", i), obi_rdata_o, vecs[i].e_rdata);
      chk($sformatf("vec%0d_err", i), 32'(obi_err_o), 32'd0);
    end

    // reset pulsed while a Wishbone cycle is active
    @(negedge clk_core);
    obi_req_i = 1'b1; obi_addr_i = 32'h300; obi_we_i = 1'b0; wb_ack_i = 1'b0;
    #1 chk("midrst_gnt", 32'(obi_gnt_o), 32'd1);
    @(negedge clk_core);
    obi_req_i = 1'b0;
    #1 chk("midrst_cyc_before", 32'(wb_cyc_o), 32'd1);
    #2 rst_core = 1'b1;
    #1;
    chk("midrst_cyc_async", 32'(wb_cyc_o), 32'd0);
    chk("midrst_stb_async", 32'(wb_stb_o), 32'd0);
    chk("midrst_addr_async", wb_addr_o, 32'd0);
    @(negedge clk_core);
    rst_core = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h77777777;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_core);
      wb_ack_i = 1'b0;
      #1;
      chk($sformatf("midrst_no_rvalid%0d", n), 32'(obi_rvalid_o), 32'd0);
      chk($sformatf("midrst_idle_cyc%0d", n), 32'(wb_cyc_o), 32'd0);
    end
    read_txn(32'h1000, 3, 32'hDEADBEEF, 1'b0, 4, "post_rst_read");

`ifdef OBI_WB_TIMEOUT_EN
    read_txn(32'h40, 1000, 32'h12345678, 1'b1, 8, "timeout");
    read_txn(32'h44, 1, 32'h0BADF00D, 1'b0, 2, "after_timeout");
    read_txn(32'h48, 7, 32'hFEEDFACE, 1'b0, 8, "ack_at_limit");
`endif

    // randomized traffic against a transaction-level model
    apply_reset();
    begin
      bit          inbus, resp_pend, nxt_resp, hold, e_gnt;
      logic [31:0] c_addr, c_wdata, last_rdata;
      logic        c_we;
      logic [3:0]  c_wstrb;
      int unsigned waitc;
      inbus = 0; resp_pend = 0; hold = 0; last_rdata = '0; waitc = 0;
      c_addr = '0; c_wdata = '0; c_we = 0; c_wstrb = '0;
      for (int cy = 0; cy < 3000; cy++) begin
        @(negedge clk_core);
        if (!hold) begin
          obi_req_i   = ($urandom_range(0, 2) != 0);
          obi_addr_i  = $urandom;
          obi_we_i    = 1'($urandom_range(0, 1));
          obi_be_i    = 4'($urandom_range(0, 15));
          obi_wdata_i = $urandom;
        end
        wb_ack_i  = (inbus && waitc >= 4) ? 1'b1 : ($urandom_range(0, 2) == 0);
        wb_data_i = $urandom;
        #1;
        e_gnt = obi_req_i && !inbus;
        chk("rnd_gnt", 32'(obi_gnt_o), 32'(e_gnt));
        chk("rnd_cyc", 32'(wb_cyc_o), 32'(inbus));
        chk("rnd_stb", 32'(wb_stb_o), 32'(inbus));
        if (inbus) begin
          chk("rnd_we", 32'(wb_we_o), 32'(c_we));
          chk("rnd_wstrb", 32'(wb_wstrb_o), 32'(c_wstrb));
          chk("rnd_addr", wb_addr_o, c_addr);
          chk("rnd_wdata", wb_data_o, c_wdata);
        end
        chk("rnd_rvalid", 32'(obi_rvalid_o), 32'(resp_pend));
        chk("rnd_rdata", obi_rdata_o, last_rdata);
        chk("rnd_err", 32'(obi_err_o), 32'd0);
        nxt_resp = 1'b0;
        if (inbus && wb_ack_i) begin
          nxt_resp   = 1'b1;
          last_rdata = c_we ? 32'h0 : wb_data_i;
          inbus      = 1'b0;
        end else if (inbus) begin
          waitc++;
        end
        if (e_gnt) begin
          inbus   = 1'b1;
          c_addr  = obi_addr_i;
          c_we    = obi_we_i;
          c_wstrb = obi_we_i ? obi_be_i : 4'hF;
          c_wdata = obi_wdata_i;
          waitc   = 0;
          hold    = 1'b0;
        end else begin
          hold = obi_req_i;
        end
        resp_pend = nxt_resp;
      end
    end

    obi_req_i = 1'b0; wb_ack_i = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/obi_wb_bridge.md
Name: obi_wb_bridge

Overview:
- Converts the cv32e40p OBI master port (req/gnt/rvalid) into the single-outstanding Wishbone classic master port (cyc/stb/we/wstrb/ack) consumed by Controller.
- Sits directly downstream of the core in processorci_top.
- One instance bridges the instruction port; a second bridges the data port when ENABLE_SECOND_MEMORY is set.
- Replaces the current tie-offs, where rvalid is forced to 1 and gnt is wired to ack.

Parameters:
- ADDR_WIDTH, 32, width of the OBI and Wishbone address.
- DATA_WIDTH, 32, width of the data buses; must be 32 (4 byte enables).
- TIMEOUT_CYCLES, 1024, ack wait limit in cycles; used only with OBI_WB_TIMEOUT_EN.

Ports:
- clk_core  in  1  core clock; all logic on rising edge.
- rst_core  in  1  asynchronous, active-high reset.
- obi_req_i  in  1  OBI request valid.
- obi_gnt_o  out  1  OBI grant; combinational.
- obi_addr_i  in  ADDR_WIDTH  request address.
- obi_we_i  in  1  1 = write.
- obi_be_i  in  4  byte enables.
- obi_wdata_i  in  DATA_WIDTH  write data.
- obi_rvalid_o  out  1  response valid; one-cycle pulse.
- obi_rdata_o  out  DATA_WIDTH  read data.
- obi_err_o  out  1  response error; valid with rvalid.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_wstrb_o  out  4  Wishbone byte strobes.
- wb_addr_o  out  ADDR_WIDTH  Wishbone address.
- wb_data_o  out  DATA_WIDTH  Wishbone write data.
- wb_data_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset values:
  - Registered outputs: wb_cyc_o, wb_stb_o, wb_we_o, obi_rvalid_o and obi_err_o = 0.
  - wb_wstrb_o, wb_addr_o, wb_data_o and obi_rdata_o = 0.
  - FSM in IDLE.
- FSM states:
  - IDLE: nothing outstanding.
  - BUS: Wishbone cycle active.
  - RESP: rvalid being presented.
- Grant rule: obi_gnt_o = obi_req_i && (state==IDLE || state==RESP). At most one transaction is outstanding at a time.
- On a grant (req && gnt):
  - Latch addr, we, be and wdata into the wb_* registers.
  - If we=0, wb_wstrb_o = 4'hF (reads fetch the full word); otherwise wb_wstrb_o = be.
  - Next state = BUS, with wb_cyc_o and wb_stb_o asserted from the following cycle.
- BUS:
  - cyc, stb, we, addr, data and wstrb are held stable until wb_ack_i.
  - On ack: cyc and stb deassert next cycle.
  - On ack, read: obi_rdata_o <= wb_data_i.
  - On ack, write: obi_rdata_o <= 0.
  - On ack: obi_rvalid_o <= 1, obi_err_o <= 0, next state = RESP.
- RESP:
  - obi_rvalid_o is high for exactly one cycle.
  - A grant in this cycle goes to BUS (back-to-back); otherwise the next state is IDLE and rvalid drops.
- Latency: grant at cycle N, cyc/stb at N+1. With ack at N+1+k, rvalid is at N+2+k. Minimum request-to-response is 2 cycles.
- Writes always produce exactly one rvalid, as OBI requires.
- wb_ack_i outside BUS is ignored: no rvalid and no state change.
- wb_data_i is sampled only in the ack cycle.
- obi_rdata_o holds its value after rvalid until the next response.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously. The pending transaction is dropped with no rvalid.
- Address and data pass through unmodified; no alignment or width arithmetic is applied.

Optional Feature:
- Macro: OBI_WB_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES without ack: cyc and stb drop, then a RESP is issued with obi_err_o=1 and obi_rdata_o=0.
  - If ack and the timeout hit in the same cycle, the ack wins and err=0.
- When undefined:
  - No counter is present and BUS waits indefinitely.
  - obi_err_o is tied to 0.

Test Plan:
- Single read: req at addr 0x1000, ack after 3 cycles with data 0xDEADBEEF -> cyc/stb high for exactly 4 cycles, wb_wstrb=0xF, one rvalid pulse with rdata=0xDEADBEEF, err=0.
- Single write: addr 0x2004, be=0x3, wdata=0x0000CAFE, ack in the first cycle -> wb_we=1, wb_wstrb=0x3, wb_data=0x0000CAFE, rvalid 2 cycles after grant, rdata=0.
- Back-to-back reads at 0x0 and 0x4, each acked immediately, req held high -> second grant coincides with the first rvalid cycle, second cyc starts the next cycle, 2 rvalids in order with matching data, no gap in cyc beyond 1 cycle.
- Spurious ack while IDLE, plus req held while BUS -> no rvalid and gnt stays 0 until RESP.
- rst_core pulsed while BUS with cyc=1 -> cyc/stb drop in the same cycle (async), no rvalid; a later read completes normally.
- With OBI_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> cyc drops after 8 BUS cycles, rvalid=1 with err=1 and rdata=0; a following acked read returns err=0.
